overlay_cmd_seq: RTL and testbench

OVERLAY_CMD_SEQ -- requirements
Module: overlay_cmd_seq

---
 rtl/overlay_cmd_seq.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_overlay_cmd_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_cmd_seq.sv
// overlay_cmd_seq: walks the overlay description once per frame and streams
// draw commands (CLEAR, then text characters, then rectangles) over a
// valid/ready handshake, flipping the framebuffer bank at each frame start.
// Optional feature: define OVERLAY_RECT_LABEL_EN to follow every rectangle
// with a two-digit upper-case hex label of its slot index.
module overlay_cmd_seq #(
  parameter int RECT_N  = 16,
  parameter int STR_N   = 16,
  parameter int STR_LEN = 16,
  parameter int COORD_W = 10
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            i_frame_start,
  input  logic [RECT_N*4*COORD_W-1:0]     i_rect_xyxy,
  input  logic [RECT_N-1:0]               i_rect_vld,
  input  logic [STR_N*STR_LEN*8-1:0]      i_str_chars,
  input  logic [STR_N*2*COORD_W-1:0]      i_str_pos,
  input  logic [STR_N*3-1:0]              i_str_color,
  output logic                            o_cmd_valid,
  input  logic                            i_cmd_ready,
  output logic [1:0]                      o_cmd_op,
  output logic [7:0]                      o_cmd_ascii,
  output logic [2:0]                      o_cmd_color,
  output logic [COORD_W-1:0]              o_cmd_x,
  output logic [COORD_W-1:0]              o_cmd_y,
  output logic [COORD_W-1:0]              o_cmd_x2,
  output logic [COORD_W-1:0]              o_cmd_y2,
  output logic                            o_bank,
  output logic                            o_busy,
  output logic                            o_overrun
);

  localparam int SW = (STR_N > 1) ? $clog2(STR_N) : 1;
  localparam int CW = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;
  localparam int RW = $clog2(RECT_N + 1);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_CHAR  = 2'd1;
  localparam logic [1:0] OP_RECT  = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    CHAR  = 3'd2,
    RECT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        sIdx_q, sIdx_d;
  logic [CW-1:0]        cIdx_q, cIdx_d;
  logic [RW-1:0]        rIdx_q, rIdx_d;
  logic                 cmdValid_q, cmdValid_d;
  logic [1:0]           cmdOp_q, cmdOp_d;
  logic [7:0]           cmdAscii_q, cmdAscii_d;
  logic [2:0]           cmdColor_q, cmdColor_d;
  logic [COORD_W-1:0]   cmdX_q, cmdX_d;
  logic [COORD_W-1:0]   cmdY_q, cmdY_d;
  logic [COORD_W-1:0]   cmdX2_q, cmdX2_d;
  logic [COORD_W-1:0]   cmdY2_q, cmdY2_d;
  logic                 bank_q, bank_d;
  logic                 overrun_q, overrun_d;

  // Candidate fields for the character and rectangle under the cursors
  logic [7:0]           curChar;
  logic [2:0]           strColor;
  logic [COORD_W-1:0]   strX, strY, charX;
  logic [RW-1:0]        rSel;
  logic [4*COORD_W-1:0] rectSlot;
  logic [RECT_N-1:0]    vldShift;
  logic [COORD_W-1:0]   rX1, rY1, rX2, rY2;
  logic                 rectOk;
  logic                 advance;
  logic                 lastStr;

`ifdef OVERLAY_RECT_LABEL_EN
  logic [1:0]           lbl_q, lbl_d;
  logic [7:0]           slotIdx;
  logic [COORD_W-1:0]   labelY;

  function automatic logic [7:0] hexChar(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction
`endif

  // The rectangle cursor runs one past the last slot to mark "all done";
  // clamp it so the slot lookup never reads outside the input vector.
  assign rSel = (rIdx_q < RW'(RECT_N)) ? rIdx_q : '0;

  // Decode the string character and rectangle slot the cursors point at
  always_comb begin
    curChar  = i_str_chars[(int'(sIdx_q) * STR_LEN + int'(cIdx_q)) * 8 +: 8];
    strColor = i_str_color[int'(sIdx_q) * 3 +: 3];
    strX     = i_str_pos[int'(sIdx_q) * 2 * COORD_W + COORD_W +: COORD_W];
    strY     = i_str_pos[int'(sIdx_q) * 2 * COORD_W +: COORD_W];
    charX    = strX + (COORD_W'(cIdx_q) << 3);
    rectSlot = i_rect_xyxy[int'(rSel) * 4 * COORD_W +: 4 * COORD_W];
    rX1      = rectSlot[4*COORD_W-1 -: COORD_W];
    rY1      = rectSlot[3*COORD_W-1 -: COORD_W];
    rX2      = rectSlot[2*COORD_W-1 -: COORD_W];
    rY2      = rectSlot[COORD_W-1:0];
    vldShift = i_rect_vld >> rSel;
    rectOk   = vldShift[0] && (rX2 >= rX1) && (rY2 >= rY1);
    lastStr  = (sIdx_q == SW'(STR_N - 1));
`ifdef OVERLAY_RECT_LABEL_EN
    slotIdx  = 8'(rSel);
    labelY   = (rY1 >= COORD_W'(10)) ? (rY1 - COORD_W'(10)) : '0;
`endif
  end

  // Next-state logic: the output register is refilled whenever it is empty
  // or its command is being taken; a cursor position that yields nothing
  // (terminator, empty or invalid slot) costs one empty cycle.
  always_comb begin
    state_d    = state_q;
    sIdx_d     = sIdx_q;
    cIdx_d     = cIdx_q;
    rIdx_d     = rIdx_q;
    cmdValid_d = cmdValid_q;
    cmdOp_d    = cmdOp_q;
    cmdAscii_d = cmdAscii_q;
    cmdColor_d = cmdColor_q;
    cmdX_d     = cmdX_q;
    cmdY_d     = cmdY_q;
    cmdX2_d    = cmdX2_q;
    cmdY2_d    = cmdY2_q;
    bank_d     = bank_q;
    overrun_d  = overrun_q;
`ifdef OVERLAY_RECT_LABEL_EN
    lbl_d      = lbl_q;
`endif
    advance    = !cmdValid_q || i_cmd_ready;

    if (i_frame_start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          bank_d     = ~bank_q;
          state_d    = CLEAR;
          cmdValid_d = 1'b1;
          cmdOp_d    = OP_CLEAR;
          cmdAscii_d = '0;
          cmdColor_d = '0;
          cmdX_d     = '0;
          cmdY_d     = '0;
          cmdX2_d    = '0;
          cmdY2_d    = '0;
          sIdx_d     = '0;
          cIdx_d     = '0;
          rIdx_d     = '0;
`ifdef OVERLAY_RECT_LABEL_EN
          lbl_d      = 2'd0;
`endif
        end
      end

      CLEAR, CHAR: begin
        if (advance) begin
          cmdValid_d = 1'b0;
          state_d    = CHAR;
          if (curChar != 8'h00) begin
            cmdValid_d = 1'b1;
            cmdOp_d    = OP_CHAR;
            cmdAscii_d = curChar;
            cmdColor_d = strColor;
            cmdX_d     = charX;
            cmdY_d     = strY;
            cmdX2_d    = '0;
            cmdY2_d    = '0;
          end
          if ((curChar == 8'h00) || (cIdx_q == CW'(STR_LEN - 1))) begin
            cIdx_d = '0;
            if (lastStr) begin
              state_d = RECT;
            end else begin
              sIdx_d = sIdx_q + SW'(1);
            end
          end else begin
            cIdx_d = cIdx_q + CW'(1);
          end
        end
      end

      RECT: begin
        if (advance) begin
          cmdValid_d = 1'b0;
          if (rIdx_q == RW'(RECT_N)) begin
            state_d = DONE;
          end
`ifdef OVERLAY_RECT_LABEL_EN
          else if (lbl_q == 2'd1) begin
            cmdValid_d = 1'b1;
            cmdOp_d    = OP_CHAR;
            cmdAscii_d = hexChar(slotIdx[7:4]);
            cmdColor_d = 3'b010;
            cmdX_d     = rX1;
            cmdY_d     = labelY;
            cmdX2_d    = '0;
            cmdY2_d    = '0;
            lbl_d      = 2'd2;
          end else if (lbl_q == 2'd2) begin
            cmdValid_d = 1'b1;
            cmdOp_d    = OP_CHAR;
            cmdAscii_d = hexChar(slotIdx[3:0]);
            cmdColor_d = 3'b010;
            cmdX_d     = rX1 + COORD_W'(8);
            cmdY_d     = labelY;
            cmdX2_d    = '0;
            cmdY2_d    = '0;
            lbl_d      = 2'd0;
            rIdx_d     = rIdx_q + RW'(1);
          end
`endif
          else if (rectOk) begin
            cmdValid_d = 1'b1;
            cmdOp_d    = OP_RECT;
            cmdAscii_d = '0;
            cmdColor_d = 3'b011;
            cmdX_d     = rX1;
            cmdY_d     = rY1;
            cmdX2_d    = rX2;
            cmdY2_d    = rY2;
`ifdef OVERLAY_RECT_LABEL_EN
            lbl_d      = 2'd1;
`else
            rIdx_d     = rIdx_q + RW'(1);
`endif
          end else begin
            rIdx_d = rIdx_q + RW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, cursors and the registered command; reset drops any pending command
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      sIdx_q     <= '0;
      cIdx_q     <= '0;
      rIdx_q     <= '0;
      cmdValid_q <= 1'b0;
      cmdOp_q    <= '0;
      cmdAscii_q <= '0;
      cmdColor_q <= '0;
      cmdX_q     <= '0;
      cmdY_q     <= '0;
      cmdX2_q    <= '0;
      cmdY2_q    <= '0;
      bank_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef OVERLAY_RECT_LABEL_EN
      lbl_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      sIdx_q     <= sIdx_d;
      cIdx_q     <= cIdx_d;
      rIdx_q     <= rIdx_d;
      cmdValid_q <= cmdValid_d;
      cmdOp_q    <= cmdOp_d;
      cmdAscii_q <= cmdAscii_d;
      cmdColor_q <= cmdColor_d;
      cmdX_q     <= cmdX_d;
      cmdY_q     <= cmdY_d;
      cmdX2_q    <= cmdX2_d;
      cmdY2_q    <= cmdY2_d;
      bank_q     <= bank_d;
      overrun_q  <= overrun_d;
`ifdef OVERLAY_RECT_LABEL_EN
      lbl_q      <= lbl_d;
`endif
    end
  end

  assign o_cmd_valid = cmdValid_q;
  assign o_cmd_op    = cmdOp_q;
  assign o_cmd_ascii = cmdAscii_q;
  assign o_cmd_color = cmdColor_q;
  assign o_cmd_x     = cmdX_q;
  assign o_cmd_y     = cmdY_q;
  assign o_cmd_x2    = cmdX2_q;
  assign o_cmd_y2    = cmdY2_q;
  assign o_bank      = bank_q;
  assign o_busy      = (state_q != IDLE);
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_overlay_cmd_seq.sv
// Testbench for overlay_cmd_seq: a reference model turns the overlay inputs
// into the expected command list before each frame, and a monitor pops and
// compares every accepted command (and the held payload during stalls).
module tb_overlay_cmd_seq;

  localparam int RECT_N  = 16;
  localparam int STR_N   = 16;
  localparam int STR_LEN = 16;
  localparam int COORD_W = 10;

  logic                        sys_clk;
  logic                        sys_rst_n;
  logic                        i_frame_start;
  logic [RECT_N*4*COORD_W-1:0] rectXyxy;
  logic [RECT_N-1:0]           rectVld;
  logic [STR_N*STR_LEN*8-1:0]  strChars;
  logic [STR_N*2*COORD_W-1:0]  strPos;
  logic [STR_N*3-1:0]          strColor;
  logic                        o_cmd_valid;
  logic                        i_cmd_ready;
  logic [1:0]                  o_cmd_op;
  logic [7:0]                  o_cmd_ascii;
  logic [2:0]                  o_cmd_color;
  logic [COORD_W-1:0]          o_cmd_x, o_cmd_y, o_cmd_x2, o_cmd_y2;
  logic                        o_bank, o_busy, o_overrun;

  int          testsRun   = 0;
  int          failCount  = 0;
  int          extraCmds  = 0;
  int          readyMode  = 0;
  int          holdCnt    = 0;
  int          stallCnt   = 0;
  bit          stallDone  = 0;
  bit          pendingAfter = 0;
  bit          expBank    = 0;
  logic [63:0] expQ[$];

  overlay_cmd_seq #(
    .RECT_N(RECT_N), .STR_N(STR_N), .STR_LEN(STR_LEN), .COORD_W(COORD_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_frame_start(i_frame_start),
    .i_rect_xyxy(rectXyxy), .i_rect_vld(rectVld), .i_str_chars(strChars),
    .i_str_pos(strPos), .i_str_color(strColor), .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready), .o_cmd_op(o_cmd_op), .o_cmd_ascii(o_cmd_ascii),
    .o_cmd_color(o_cmd_color), .o_cmd_x(o_cmd_x), .o_cmd_y(o_cmd_y),
    .o_cmd_x2(o_cmd_x2), .o_cmd_y2(o_cmd_y2), .o_bank(o_bank),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] packCmd(input logic [1:0] op, input logic [7:0] a,
                                          input logic [2:0] c, input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x2,
                                          input logic [COORD_W-1:0] y2);
    return 64'({op, a, c, x, y, x2, y2});
  endfunction

`ifdef OVERLAY_RECT_LABEL_EN
  function automatic logic [7:0] hexAscii(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction
`endif

  // Reference model of one frame's command list
  task automatic buildExpected();
    logic [COORD_W-1:0] px, py, x1, y1, x2, y2, ly;
    logic [2:0]         col;
    logic [7:0]         ch;
    logic [4*COORD_W-1:0] slot;
    expQ.push_back(packCmd(2'd0, 8'h00, 3'd0, '0, '0, '0, '0));
    for (int s = 0; s < STR_N; s++) begin
      px  = strPos[s*2*COORD_W + COORD_W +: COORD_W];
      py  = strPos[s*2*COORD_W +: COORD_W];
      col = strColor[s*3 +: 3];
      for (int c = 0; c < STR_LEN; c++) begin
        ch = strChars[(s*STR_LEN + c)*8 +: 8];
        if (ch == 8'h00) break;
        expQ.push_back(packCmd(2'd1, ch, col, COORD_W'(int'(px) + 8*c), py, '0, '0));
      end
    end
    for (int k = 0; k < RECT_N; k++) begin
      slot = rectXyxy[k*4*COORD_W +: 4*COORD_W];
      x1 = slot[4*COORD_W-1 -: COORD_W];
      y1 = slot[3*COORD_W-1 -: COORD_W];
      x2 = slot[2*COORD_W-1 -: COORD_W];
      y2 = slot[COORD_W-1:0];
      if (rectVld[k] && (x2 >= x1) && (y2 >= y1)) begin
        expQ.push_back(packCmd(2'd2, 8'h00, 3'b011, x1, y1, x2, y2));
`ifdef OVERLAY_RECT_LABEL_EN
        ly = (y1 >= 10) ? COORD_W'(int'(y1) - 10) : '0;
        expQ.push_back(packCmd(2'd1, hexAscii(k / 16), 3'b010, x1, ly, '0, '0));
        expQ.push_back(packCmd(2'd1, hexAscii(k % 16), 3'b010, COORD_W'(int'(x1) + 8), ly, '0, '0));
`else
        ly = '0;
`endif
      end
    end
  endtask

  task automatic clearInputs();
    rectXyxy = '0; rectVld = '0; strChars = '0; strPos = '0; strColor = '0;
  endtask

  task automatic setString(input int s, input string txt, input int x, input int y, input int col);
    for (int i = 0; i < STR_LEN; i++) strChars[(s*STR_LEN + i)*8 +: 8] = 8'h00;
    for (int i = 0; i < txt.len() && i < STR_LEN; i++) strChars[(s*STR_LEN + i)*8 +: 8] = txt[i];
    strPos[s*2*COORD_W +: 2*COORD_W] = {COORD_W'(x), COORD_W'(y)};
    strColor[s*3 +: 3] = 3'(col);
  endtask

  task automatic setRect(input int k, input int x1, input int y1, input int x2, input int y2, input bit v);
    rectXyxy[k*4*COORD_W +: 4*COORD_W] = {COORD_W'(x1), COORD_W'(y1), COORD_W'(x2), COORD_W'(y2)};
    rectVld[k] = v;
  endtask

  // Build the expected list and pulse i_frame_start for one cycle
  task automatic applyStimulus();
    buildExpected();
    @(posedge sys_clk); #1;
    i_frame_start = 1'b1;
    @(posedge sys_clk); #1;
    i_frame_start = 1'b0;
    expBank = ~expBank;
    checkOutput("busy_rise", 64'(o_busy), 64'd1);
    checkOutput("bank_toggle", 64'(o_bank), 64'(expBank));
  endtask

  task automatic waitFrameDone(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput({tag, "_in_time"}, 64'(n < 3000), 64'd1);
    checkOutput({tag, "_all_cmds"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_busy_fall"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_bank"}, 64'(o_bank), 64'(expBank));
  endtask

  // Ready generator: always-on, random, or one 5-cycle stall on a CHAR
  initial begin
    i_cmd_ready = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      case (readyMode)
        1: i_cmd_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!stallDone && o_cmd_valid && (o_cmd_op == 2'd1)) begin
            if (stallCnt < 5) begin
              i_cmd_ready = 1'b0;
              stallCnt++;
            end else begin
              i_cmd_ready = 1'b1;
              stallDone = 1'b1;
            end
          end else begin
            i_cmd_ready = 1'b1;
          end
        end
        default: i_cmd_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    logic [63:0] act;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (pendingAfter) begin
          checkOutput("after_stall_valid", 64'(o_cmd_valid), 64'd1);
          pendingAfter = 1'b0;
        end
        if (o_cmd_valid) begin
          act = packCmd(o_cmd_op, o_cmd_ascii, o_cmd_color, o_cmd_x, o_cmd_y, o_cmd_x2, o_cmd_y2);
          if (i_cmd_ready) begin
            if (expQ.size() == 0) begin
              extraCmds++;
            end else begin
              checkOutput("cmd", act, expQ.pop_front());
            end
            if (readyMode == 2 && holdCnt >= 5) pendingAfter = 1'b1;
            holdCnt = 0;
          end else if (expQ.size() != 0) begin
            checkOutput("hold", act, expQ[0]);
            holdCnt++;
          end
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 64'(o_cmd_valid), 64'd0);
    checkOutput({tag, "_bank"}, 64'(o_bank), 64'd0);
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(o_overrun), 64'd0);
    checkOutput({tag, "_payload"},
                packCmd(o_cmd_op, o_cmd_ascii, o_cmd_color, o_cmd_x, o_cmd_y, o_cmd_x2, o_cmd_y2), 64'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    i_frame_start = 1'b0;
    clearInputs();
    repeat (3) @(posedge sys_clk);
    #1;
    checkResetOutputs("rst");
    sys_rst_n = 1'b1;

    // Empty overlay: only CLEAR
    applyStimulus();
    waitFrameDone("empty");

    // "AB" at (100,20)
    setString(0, "AB", 100, 20, 5);
    applyStimulus();
    waitFrameDone("str_ab");

    // Single rectangle in slot 3
    clearInputs();
    setRect(3, 10, 5, 50, 40, 1'b1);
    applyStimulus();
    waitFrameDone("rect3");

    // Five-cycle stall on the first CHAR
    clearInputs();
    setString(0, "HELLO", 30, 40, 2);
    readyMode = 2; stallCnt = 0; stallDone = 1'b0; holdCnt = 0;
    applyStimulus();
    waitFrameDone("stall");
    checkOutput("stall_happened", 64'(stallDone), 64'd1);
    readyMode = 0;

    // Frame start while busy: flagged, otherwise ignored
    applyStimulus();
    repeat (3) @(posedge sys_clk);
    #1 i_frame_start = 1'b1;
    @(posedge sys_clk); #1 i_frame_start = 1'b0;
    checkOutput("overrun_set", 64'(o_overrun), 64'd1);
    checkOutput("overrun_bank", 64'(o_bank), 64'(expBank));
    waitFrameDone("overrun");

    // Coordinate wrap and rejected rectangles
    clearInputs();
    setString(2, "XY", 1020, 7, 6);
    setRect(0, 50, 10, 20, 30, 1'b1);
    setRect(1, 5, 30, 20, 10, 1'b1);
    setRect(2, 1, 1, 9, 9, 1'b0);
    setRect(5, 12, 12, 12, 12, 1'b1);
    applyStimulus();
    waitFrameDone("wrap");

    // Full-length string, last slots, random ready
    clearInputs();
    setString(15, "0123456789abcdef", 200, 300, 7);
    setString(7, "Hi", 0, 1023, 1);
    setRect(15, 0, 0, 1023, 1023, 1'b1);
    setRect(8, 100, 9, 200, 100, 1'b1);
    readyMode = 1;
    applyStimulus();
    waitFrameDone("random");

    // Reset in the middle of a frame
    applyStimulus();
    repeat (10) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 checkResetOutputs("midrst");
    expQ.delete();
    expBank = 1'b0;
    holdCnt = 0;
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    readyMode = 0;
    applyStimulus();
    waitFrameDone("after_rst");
    checkOutput("overrun_after_rst", 64'(o_overrun), 64'd0);

    checkOutput("extra_cmds", 64'(extraCmds), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
